// File: rtl/rice_bus_sram_pkg.sv
// Shared types for the rice bus responder: response record and index helpers.
// Used by rice_bus_sram and its response FIFO.
package rice_bus_pkg;

  localparam int RICE_BUS_DW = 32;

  typedef struct packed {
    logic [RICE_BUS_DW-1:0] read_data;
    logic                   error;
  } rice_bus_response_t;

  // Byte-offset bits inside one data word.
  function automatic int off_w(input int dw);
    return $clog2(dw / 8);
  endfunction

  // Word-index bits for a memory of 'size' bytes.
  function automatic int idx_w(input int size, input int dw);
    return $clog2(size) - $clog2(dw / 8);
  endfunction

endpackage

// File: rtl/rice_bus_sram_if.sv
// rice_bus_if: pipelined request/response bus between core and memory.
// master = requester (core), slave = responder (memory).
interface rice_bus_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic                    request_valid;
  logic                    request_ready;
  logic [ADDRESS_WIDTH-1:0] address;
  logic                    write;
  logic [DATA_WIDTH-1:0]   write_data;
  logic [DATA_WIDTH/8-1:0] strobe;
  logic                    response_valid;
  logic                    response_ready;
  logic [DATA_WIDTH-1:0]   read_data;
  logic                    error;

  modport master (
    output request_valid, address, write,
    output write_data, strobe, response_ready,
    input  request_ready, response_valid,
    input  read_data, error
  );

  modport slave (
    input  request_valid, address, write,
    input  write_data, strobe, response_ready,
    output request_ready, response_valid,
    output read_data, error
  );
endinterface

// File: rtl/rice_bus_sram_fifo.sv
// rice_bus_response_fifo: small synchronous FIFO of bus responses.
// Pointers wrap modulo DEPTH; count reports occupancy.
module rice_bus_response_fifo
  import rice_bus_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_push,
  input  rice_bus_response_t i_push_data,
  input  logic               i_pop,
  output rice_bus_response_t o_head,
  output logic               o_full,
  output logic               o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  rice_bus_response_t r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Storage and pointer/occupancy bookkeeping.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/rice_bus_sram.sv
// rice_bus_sram: bus responder backed by on-chip word memory, in-order responses.
// Optional macro RICE_BUS_SRAM_ERROR_EN: out-of-range addresses return error.
module rice_bus_sram
  import rice_bus_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = RICE_BUS_DW,
  parameter int SIZE           = 4096,
  parameter int RESPONSE_DEPTH = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  rice_bus_if.slave  bus_if
);
  localparam int WORDS = SIZE / (DATA_WIDTH / 8);
  localparam int OFF_W = off_w(DATA_WIDTH);
  localparam int IDX_W = idx_w(SIZE, DATA_WIDTH);
  localparam int CW    = $clog2(RESPONSE_DEPTH + 1);

  logic [DATA_WIDTH-1:0] r_mem [WORDS];
  logic                  r_inf_valid;
  rice_bus_response_t    r_inf_resp;

  logic [IDX_W-1:0] w_idx;
  logic             w_err;
  logic             w_accept;
  logic             w_ready;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [CW-1:0]    w_count;
  logic [CW:0]      w_used;
  rice_bus_response_t w_head;
  logic             w_unused;

  assign w_idx = bus_if.address[IDX_W+OFF_W-1:OFF_W];

`ifdef RICE_BUS_SRAM_ERROR_EN
  assign w_err = (bus_if.address >= ADDRESS_WIDTH'(SIZE));
`else
  assign w_err = 1'b0;
`endif

  assign w_unused = ^{bus_if.address, w_full};

  // A pop this cycle frees a slot, so ready can follow response_ready.
  assign w_pop    = !w_empty && bus_if.response_ready;
  assign w_used   = (CW+1)'(w_count) + (CW+1)'(r_inf_valid)
                  - (CW+1)'(w_pop);
  assign w_ready  = !i_rst && (w_used < (CW+1)'(RESPONSE_DEPTH));
  assign w_accept = bus_if.request_valid && w_ready;

  assign bus_if.request_ready  = w_ready;
  assign bus_if.response_valid = !w_empty;
  assign bus_if.read_data      = w_empty ? '0 : w_head.read_data;
  assign bus_if.error          = !w_empty && w_head.error;

  // Byte-enabled memory write at the accept edge; memory is never reset.
  always_ff @(posedge i_clk) begin
    if (w_accept && bus_if.write && !w_err) begin
      for (int i = 0; i < DATA_WIDTH / 8; i++) begin
        if (bus_if.strobe[i])
          r_mem[w_idx][8*i +: 8] <= bus_if.write_data[8*i +: 8];
      end
    end
  end

  // In-flight stage: captures the response of the request accepted this edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_inf_valid <= 1'b0;
      r_inf_resp  <= '0;
    end else begin
      r_inf_valid <= w_accept;
      if (w_accept) begin
        r_inf_resp.error     <= w_err;
        r_inf_resp.read_data <= (bus_if.write || w_err)
                                ? '0 : r_mem[w_idx];
      end
    end
  end

  rice_bus_response_fifo #(
    .DEPTH (RESPONSE_DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (r_inf_valid),
    .i_push_data (r_inf_resp),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count)
  );

endmodule

// File: tb/tb_rice_bus_sram.sv
// Testbench for rice_bus_sram: directed table, corner sequences, random traffic.
// Build with +define+RICE_BUS_SRAM_ERROR_EN to exercise the error path.
module tb_rice_bus_sram;
  import rice_bus_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rice_bus_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus ();

  rice_bus_sram #(
    .ADDRESS_WIDTH  (32),
    .DATA_WIDTH     (32),
    .SIZE           (4096),
    .RESPONSE_DEPTH (2)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .bus_if (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [31:0] mmem [1024];
  logic [32:0] expq [$];
  int          pop_cyc [$];
  logic        acc, pop, rdy;
  logic [31:0] pdata;
  logic        perr;

  function automatic void chk(input string nm,
                              input logic [63:0] act,
                              input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic logic addr_err(input logic [31:0] a);
    logic e;
    e = 1'b0;
`ifdef RICE_BUS_SRAM_ERROR_EN
    e = (a >= 32'd4096);
`endif
    return e;
  endfunction

  // Reference: memory as an array of words, responses as an ordered queue.
  function automatic void model_accept(input logic [31:0] a,
                                       input logic w,
                                       input logic [31:0] d,
                                       input logic [3:0] s);
    int idx;
    idx = int'(a[11:2]);
    if (addr_err(a)) begin
      expq.push_back({1'b1, 32'h0});
    end else if (w) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) mmem[idx][8*b +: 8] = d[8*b +: 8];
      expq.push_back(33'h0);
    end else begin
      expq.push_back({1'b0, mmem[idx]});
    end
  endfunction

  task automatic step(input logic v, input logic [31:0] a,
                      input logic w, input logic [31:0] d,
                      input logic [3:0] s, input logic rr);
    logic [32:0] e;
    @(negedge clk);
    bus.request_valid  = v;
    bus.address        = a;
    bus.write          = w;
    bus.write_data     = d;
    bus.strobe         = s;
    bus.response_ready = rr;
    #1;
    cyc++;
    rdy   = bus.request_ready;
    acc   = v && rdy;
    pop   = bus.response_valid && rr;
    pdata = bus.read_data;
    perr  = bus.error;
    if (pop) begin
      pop_cyc.push_back(cyc);
      if (expq.size() == 0) begin
        chk("spurious_resp", 64'(bus.response_valid), 64'd0);
      end else begin
        e = expq.pop_front();
        chk("model_resp", 64'({perr, pdata}), 64'(e));
      end
    end
    if (acc) model_accept(a, w, d, s);
  endtask

  task automatic idle(input logic rr);
    step(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, rr);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expq.size() != 0 && n < 50) begin
      idle(1'b1);
      n++;
    end
    chk("drain_empty", 64'(expq.size()), 64'd0);
  endtask

  task automatic txn(input vec_t t, output logic [31:0] rd,
                     output logic re, output int lat);
    int n;
    n = 0;
    do begin
      step(1'b1, t.addr, t.wr, t.data, t.strb, 1'b1);
      n++;
    end while (!acc && n < 10);
    chk("txn_accept", 64'(acc), 64'd1);
    lat = 0;
    do begin
      idle(1'b1);
      lat++;
    end while (!pop && lat < 10);
    rd = pdata;
    re = perr;
  endtask

  vec_t        tbl [11];
  logic [31:0] rd;
  logic        re;
  int          lat;
  logic [31:0] head0;
  logic        rdy_pat [4];
  int          np;
  vec_t        tv;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) mmem[i] = 32'h0;
    bus.request_valid  = 1'b0;
    bus.address        = 32'h0;
    bus.write          = 1'b0;
    bus.write_data     = 32'h0;
    bus.strobe         = 4'h0;
    bus.response_ready = 1'b0;

    // Reset held three cycles.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_ready", 64'(bus.request_ready), 64'd0);
    chk("rst_resp_valid", 64'(bus.response_valid), 64'd0);
    chk("rst_read_data", 64'(bus.read_data), 64'd0);
    chk("rst_error", 64'(bus.error), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 64'(bus.request_ready), 64'd1);

    // Directed transactions, expectations straight from the bus rules.
    tbl[0]  = '{32'h10,   1'b1, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0};
    tbl[1]  = '{32'h10,   1'b0, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0};
    tbl[2]  = '{32'h10,   1'b1, 32'h0000AB00, 4'h2, 32'h0, 1'b0};
    tbl[3]  = '{32'h10,   1'b0, 32'h0, 4'h0, 32'hDEADABEF, 1'b0};
    tbl[4]  = '{32'h0,    1'b1, 32'h12345678, 4'hF, 32'h0, 1'b0};
`ifdef RICE_BUS_SRAM_ERROR_EN
    tbl[5]  = '{32'h1000, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1};
`else
    tbl[5]  = '{32'h1000, 1'b0, 32'h0, 4'h0, 32'h12345678, 1'b0};
`endif
    tbl[6]  = '{32'hFFC,  1'b1, 32'h11223344, 4'hF, 32'h0, 1'b0};
    tbl[7]  = '{32'hFFD,  1'b1, 32'hA5A5A5A5, 4'h9, 32'h0, 1'b0};
    tbl[8]  = '{32'hFFE,  1'b0, 32'h0, 4'h0, 32'hA52233A5, 1'b0};
`ifdef RICE_BUS_SRAM_ERROR_EN
    tbl[9]  = '{32'h1010, 1'b1, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1};
    tbl[10] = '{32'h10,   1'b0, 32'h0, 4'h0, 32'hDEADABEF, 1'b0};
`else
    tbl[9]  = '{32'h1010, 1'b1, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b0};
    tbl[10] = '{32'h10,   1'b0, 32'h0, 4'h0, 32'hFFFFFFFF, 1'b0};
`endif

    for (int i = 0; i < 11; i++) begin
      txn(tbl[i], rd, re, lat);
      chk($sformatf("tbl%0d_data", i), 64'(rd), 64'(tbl[i].exp_data));
      chk($sformatf("tbl%0d_err", i), 64'(re), 64'(tbl[i].exp_err));
      chk($sformatf("tbl%0d_lat", i), 64'(lat), 64'd2);
    end

    // Prefill words 0..63 back-to-back.
    for (int i = 0; i < 64; i++) begin
      step(1'b1, 32'(i * 4), 1'b1, $urandom, 4'hF, 1'b1);
      chk("prefill_acc", 64'(acc), 64'd1);
    end
    drain();

    // Eight back-to-back reads: no ready drop, eight consecutive responses.
    pop_cyc.delete();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 32'(i * 4), 1'b0, 32'h0, 4'h0, 1'b1);
      chk("b2b_ready", 64'(acc), 64'd1);
    end
    drain();
    chk("b2b_count", 64'(pop_cyc.size()), 64'd8);
    if (pop_cyc.size() == 8)
      chk("b2b_span", 64'(pop_cyc[7] - pop_cyc[0]), 64'd7);

    // Backpressure: two accepts, then ready low; head held.
    pop_cyc.delete();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 32'(32 + i * 4), 1'b0, 32'h0, 4'h0, 1'b0);
      rdy_pat[i] = rdy;
      if (i == 2) head0 = bus.read_data;
    end
    chk("bp_rdy0", 64'(rdy_pat[0]), 64'd1);
    chk("bp_rdy1", 64'(rdy_pat[1]), 64'd1);
    chk("bp_rdy2", 64'(rdy_pat[2]), 64'd0);
    chk("bp_rdy3", 64'(rdy_pat[3]), 64'd0);
    chk("bp_valid", 64'(bus.response_valid), 64'd1);
    chk("bp_head_stable", 64'(bus.read_data), 64'(head0));
    chk("bp_head_val", 64'(bus.read_data), 64'(mmem[8]));
    drain();
    chk("bp_no_dup", 64'(pop_cyc.size()), 64'd2);

    // Reset mid-operation: pending responses dropped, write kept.
    step(1'b1, 32'h100, 1'b1, 32'h600DF00D, 4'hF, 1'b0);
    chk("mid_wr_acc", 64'(acc), 64'd1);
    step(1'b1, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0);
    @(negedge clk);
    bus.request_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(bus.response_valid), 64'd0);
    chk("mid_rst_ready", 64'(bus.request_ready), 64'd0);
    expq.delete();
    @(negedge clk);
    rst = 1'b0;
    tv = '{32'h100, 1'b0, 32'h0, 4'h0, 32'h600DF00D, 1'b0};
    txn(tv, rd, re, lat);
    chk("mid_rst_keep", 64'(rd), 64'(tv.exp_data));

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0)
        a = a + 32'($urandom_range(1, 3) * 32'h1000);
      step(1'($urandom_range(0, 1)), a, 1'($urandom_range(0, 1)),
           $urandom, 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 3) != 0));
    end
    drain();
    np = 0;
    repeat (3) begin
      idle(1'b1);
      if (bus.response_valid) np++;
    end
    chk("final_idle", 64'(np), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
